jtag_tap_oversampled: RTL and testbench

// - JTAG TAP responder running entirely on clk_i. It oversamples the TCK/TMS/TDI/TRST pins

---
 rtl/jtag_tap_oversampled.sv | 214 +++++++++++++++++++++
 tb/tb_jtag_tap_oversampled.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_oversampled.sv
// JTAG TAP responder oversampled on clk_i: 16-state controller, 5-bit IR,
// BYPASS / IDCODE / CONFREG data registers.
// Optional USERREG (IR 5'b01000, 32-bit) when JTAG_TAP_USERREG_EN is defined.
module jtag_tap_oversampled #(
  parameter logic [31:0] IDCODE_VAL = 32'h249511C3,
  parameter int unsigned IR_WIDTH   = 5,
  parameter logic [8:0]  CONF_RST   = 9'h000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        jtag_tck_i,
  input  logic        jtag_trst_ni,
  input  logic        jtag_tms_i,
  input  logic        jtag_tdi_i,
  output logic        jtag_tdo_o,
  output logic [8:0]  conf_reg_o,
  output logic        conf_upd_o,
  output logic        tlr_o
`ifdef JTAG_TAP_USERREG_EN
  ,
  input  logic [31:0] user_reg_i,
  output logic [31:0] user_reg_o,
  output logic        user_upd_o
`endif
);

  localparam int unsigned DR_W = 32;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(5'b00001);
  localparam logic [IR_WIDTH-1:0] IR_CONFREG = IR_WIDTH'(5'b00110);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = IR_WIDTH'(5'b11111);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(5'b00101);
`ifdef JTAG_TAP_USERREG_EN
  localparam logic [IR_WIDTH-1:0] IR_USERREG = IR_WIDTH'(5'b01000);
`endif

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {SEL_BYP, SEL_IDC, SEL_CONF, SEL_USER} dr_sel_e;

  logic [2:0]          tck_sync;
  logic [1:0]          tms_sync, tdi_sync, trst_sync;
  logic                tck_rise_q, tck_fall_q, tms_q, tdi_q;
  logic                trst_act;

  tap_state_e          state_q, state_nxt;
  logic [IR_WIDTH-1:0] ir_q, ir_shift_q;
  logic [DR_W-1:0]     dr_shift_q, dr_cap_c, dr_shf_c;
  dr_sel_e             dr_sel;
  logic [8:0]          conf_q;
  logic                conf_upd_q, tdo_q, tlr_q;
`ifdef JTAG_TAP_USERREG_EN
  logic [31:0]         user_q;
  logic                user_upd_q;
`endif

  // Pin synchronisers; edges come from the 3rd delayed TCK copy, TMS/TDI aligned to them
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync   <= '0;
      tms_sync   <= '0;
      tdi_sync   <= '0;
      trst_sync  <= '0;
      tck_rise_q <= 1'b0;
      tck_fall_q <= 1'b0;
      tms_q      <= 1'b0;
      tdi_q      <= 1'b0;
    end else begin
      tck_sync   <= {tck_sync[1:0], jtag_tck_i};
      tms_sync   <= {tms_sync[0], jtag_tms_i};
      tdi_sync   <= {tdi_sync[0], jtag_tdi_i};
      trst_sync  <= {trst_sync[0], jtag_trst_ni};
      tck_rise_q <= tck_sync[1] & ~tck_sync[2];
      tck_fall_q <= ~tck_sync[1] & tck_sync[2];
      tms_q      <= tms_sync[1];
      tdi_q      <= tdi_sync[1];
    end
  end

  assign trst_act = ~trst_sync[1];

  // IEEE 1149.1 TMS-driven state transitions
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      TLR:     state_nxt = tms_q ? TLR    : RTI;
      RTI:     state_nxt = tms_q ? SEL_DR : RTI;
      SEL_DR:  state_nxt = tms_q ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = tms_q ? EX1_DR : SH_DR;
      SH_DR:   state_nxt = tms_q ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt = tms_q ? UPD_DR : PA_DR;
      PA_DR:   state_nxt = tms_q ? EX2_DR : PA_DR;
      EX2_DR:  state_nxt = tms_q ? UPD_DR : SH_DR;
      UPD_DR:  state_nxt = tms_q ? SEL_DR : RTI;
      SEL_IR:  state_nxt = tms_q ? TLR    : CAP_IR;
      CAP_IR:  state_nxt = tms_q ? EX1_IR : SH_IR;
      SH_IR:   state_nxt = tms_q ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt = tms_q ? UPD_IR : PA_IR;
      PA_IR:   state_nxt = tms_q ? EX2_IR : PA_IR;
      EX2_IR:  state_nxt = tms_q ? UPD_IR : SH_IR;
      UPD_IR:  state_nxt = tms_q ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  // Instruction decode; unknown codes fall back to BYPASS
  always_comb begin
    dr_sel = SEL_BYP;
    case (ir_q)
      IR_IDCODE:  dr_sel = SEL_IDC;
      IR_CONFREG: dr_sel = SEL_CONF;
      IR_BYPASS:  dr_sel = SEL_BYP;
`ifdef JTAG_TAP_USERREG_EN
      IR_USERREG: dr_sel = SEL_USER;
`endif
      default:    dr_sel = SEL_BYP;
    endcase
  end

  // Capture value and one-step shift of the selected DR (TDI enters at its MSB)
  always_comb begin
    dr_cap_c = '0;
    dr_shf_c = {31'b0, tdi_q};
    case (dr_sel)
      SEL_IDC: begin
        dr_cap_c = IDCODE_VAL;
        dr_shf_c = {tdi_q, dr_shift_q[31:1]};
      end
      SEL_CONF: begin
        dr_cap_c = 32'(conf_q);
        dr_shf_c = {23'b0, tdi_q, dr_shift_q[8:1]};
      end
`ifdef JTAG_TAP_USERREG_EN
      SEL_USER: begin
        dr_cap_c = user_reg_i;
        dr_shf_c = {tdi_q, dr_shift_q[31:1]};
      end
`endif
      default: ;
    endcase
  end

  // TAP state, shift paths on TCK rise; TDO and updates on TCK fall
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TLR;
      ir_q       <= IR_IDCODE;
      ir_shift_q <= '0;
      dr_shift_q <= '0;
      conf_q     <= CONF_RST;
      conf_upd_q <= 1'b0;
      tdo_q      <= 1'b0;
      tlr_q      <= 1'b1;
`ifdef JTAG_TAP_USERREG_EN
      user_q     <= '0;
      user_upd_q <= 1'b0;
`endif
    end else begin
      conf_upd_q <= 1'b0;
`ifdef JTAG_TAP_USERREG_EN
      user_upd_q <= 1'b0;
`endif
      if (trst_act) begin
        state_q <= TLR;
        ir_q    <= IR_IDCODE;
        tlr_q   <= 1'b1;
        tdo_q   <= 1'b0;
      end else begin
        if (tck_rise_q) begin
          state_q <= state_nxt;
          tlr_q   <= (state_nxt == TLR);
          case (state_q)
            TLR:     ir_q       <= IR_IDCODE;
            CAP_IR:  ir_shift_q <= IR_CAPTURE;
            SH_IR:   ir_shift_q <= {tdi_q, ir_shift_q[IR_WIDTH-1:1]};
            CAP_DR:  dr_shift_q <= dr_cap_c;
            SH_DR:   dr_shift_q <= dr_shf_c;
            default: ;
          endcase
        end
        if (tck_fall_q) begin
          if (state_q == SH_DR)      tdo_q <= dr_shift_q[0];
          else if (state_q == SH_IR) tdo_q <= ir_shift_q[0];
          else                       tdo_q <= 1'b0;
          if (state_q == UPD_IR) ir_q <= ir_shift_q;
          if (state_q == UPD_DR && dr_sel == SEL_CONF) begin
            conf_q     <= dr_shift_q[8:0];
            conf_upd_q <= 1'b1;
          end
`ifdef JTAG_TAP_USERREG_EN
          if (state_q == UPD_DR && dr_sel == SEL_USER) begin
            user_q     <= dr_shift_q;
            user_upd_q <= 1'b1;
          end
`endif
        end
      end
    end
  end

  assign jtag_tdo_o = tdo_q;
  assign conf_reg_o = conf_q;
  assign conf_upd_o = conf_upd_q;
  assign tlr_o      = tlr_q;
`ifdef JTAG_TAP_USERREG_EN
  assign user_reg_o = user_q;
  assign user_upd_o = user_upd_q;
`endif

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Self-checking bench for jtag_tap_oversampled: randomized scans checked
// against a scan-level model of the TAP registers.
module tb_jtag_tap_oversampled;

  localparam logic [31:0] IDCODE = 32'h249511C3;
  localparam int unsigned HALF   = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tck = 1'b0, trst_n = 1'b1, tms = 1'b1, tdi = 1'b0;
  logic       tdo, upd, tlr;
  logic [8:0] conf;
`ifdef JTAG_TAP_USERREG_EN
  logic [31:0] user_in = '0;
  logic [31:0] user_out;
  logic        user_upd;
  int          user_upd_cnt = 0;
`endif

  int checks = 0, failures = 0;
  int upd_cnt = 0, exp_upd = 0;
  logic [4:0] m_ir;
  logic [8:0] m_conf;

  jtag_tap_oversampled dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .jtag_tck_i  (tck),
    .jtag_trst_ni(trst_n),
    .jtag_tms_i  (tms),
    .jtag_tdi_i  (tdi),
    .jtag_tdo_o  (tdo),
    .conf_reg_o  (conf),
    .conf_upd_o  (upd),
    .tlr_o       (tlr)
`ifdef JTAG_TAP_USERREG_EN
    ,
    .user_reg_i  (user_in),
    .user_reg_o  (user_out),
    .user_upd_o  (user_upd)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upd) upd_cnt++;
`ifdef JTAG_TAP_USERREG_EN
    if (user_upd) user_upd_cnt++;
`endif
  end

  // ---------------- reference model (scan-level) ----------------
  function automatic int dr_len(input logic [4:0] ir);
    if (ir == 5'b00001) return 32;
    if (ir == 5'b00110) return 9;
`ifdef JTAG_TAP_USERREG_EN
    if (ir == 5'b01000) return 32;
`endif
    return 1;
  endfunction

  function automatic logic [63:0] dr_cap(input logic [4:0] ir);
    if (ir == 5'b00001) return 64'(IDCODE);
    if (ir == 5'b00110) return 64'(m_conf);
`ifdef JTAG_TAP_USERREG_EN
    if (ir == 5'b01000) return 64'(user_in);
`endif
    return 64'd0;
  endfunction

  // Bits seen on TDO while n bits stream through an L-bit register holding cap
  function automatic logic [63:0] exp_out(input int n, input int len,
                                          input logic [63:0] cap, input logic [63:0] din);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = (i < len) ? cap[i] : din[i - len];
    return r;
  endfunction

  // Register contents after n bits have streamed in
  function automatic logic [63:0] exp_reg(input int n, input int len,
                                          input logic [63:0] cap, input logic [63:0] din);
    logic [63:0] r = '0;
    for (int j = 0; j < len; j++) r[j] = (j + n < len) ? cap[j + n] : din[j + n - len];
    return r;
  endfunction

  function automatic logic [63:0] mask(input int n);
    logic [63:0] one = 64'd1;
    return (n >= 64) ? '1 : ((one << n) - 64'd1);
  endfunction

  // ---------------- pin-level stimulus ----------------
  task automatic tck_cycle(input logic t_ms, input logic t_di, output logic t_do);
    tms = t_ms;
    tdi = t_di;
    #(HALF);
    t_do = tdo;
    tck = 1'b1;
    #(HALF);
    tck = 1'b0;
  endtask

  task automatic scan_ir(input logic [4:0] code, output logic [4:0] cap);
    logic b;
    tck_cycle(1, 0, b); tck_cycle(1, 0, b); tck_cycle(0, 0, b); tck_cycle(0, 0, b);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, code[i], b);
      cap[i] = b;
    end
    tck_cycle(1, 0, b); tck_cycle(0, 0, b);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1, 0, b); tck_cycle(0, 0, b); tck_cycle(0, 0, b);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], b);
      dout[i] = b;
    end
    tck_cycle(1, 0, b); tck_cycle(0, 0, b);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic b;
    rst_n = 1'b0;
    #100;
    checks++; if (tlr !== 1'b1) begin failures++; $display("FAIL rst_tlr got=%b exp=1", tlr); end
    checks++; if (tdo !== 1'b0) begin failures++; $display("FAIL rst_tdo got=%b exp=0", tdo); end
    checks++; if (conf !== 9'h000) begin failures++; $display("FAIL rst_conf got=%h exp=000", conf); end
    checks++; if (upd !== 1'b0) begin failures++; $display("FAIL rst_upd got=%b exp=0", upd); end
    rst_n = 1'b1;
    #20;
    for (int i = 0; i < 5; i++) tck_cycle(1, $urandom_range(0, 1), b);
    #50;
    checks++; if (tlr !== 1'b1) begin failures++; $display("FAIL tms5_tlr got=%b exp=1", tlr); end
    checks++; if (tdo !== 1'b0) begin failures++; $display("FAIL tms5_tdo got=%b exp=0", tdo); end
    checks++; if (conf !== 9'h000) begin failures++; $display("FAIL tms5_conf got=%h exp=000", conf); end
    tck_cycle(0, 0, b);
    checks++; if (tlr !== 1'b0) begin failures++; $display("FAIL rti_tlr got=%b exp=0", tlr); end
    m_ir = 5'b00001;
    m_conf = 9'h000;
  endtask

  task automatic test_idcode;
    logic [63:0] din, dout, e;
    din = {$urandom, $urandom};
    e = exp_out(32, dr_len(m_ir), dr_cap(m_ir), din);
    scan_dr(32, din, dout);
    checks++; if (dout[31:0] !== IDCODE) begin failures++; $display("FAIL idcode got=%h exp=%h", dout[31:0], IDCODE); end
    checks++; if (dout[31:0] !== e[31:0]) begin failures++; $display("FAIL idcode_model got=%h exp=%h", dout[31:0], e[31:0]); end
    #50;
    checks++; if (tdo !== 1'b0) begin failures++; $display("FAIL tdo_idle got=%b exp=0", tdo); end
  endtask

  task automatic test_bypass;
    logic [4:0] cap, code;
    logic [63:0] din, dout, e;
    int n;
    scan_ir(5'b11111, cap);
    m_ir = 5'b11111;
    checks++; if (cap !== 5'b00101) begin failures++; $display("FAIL ir_capture got=%b exp=00101", cap); end
    scan_dr(9, 64'hA5, dout);
    checks++; if (dout[8:0] !== 9'h14A) begin failures++; $display("FAIL bypass_a5 got=%h exp=14a", dout[8:0]); end
    for (int k = 0; k < 5; k++) begin
      code = 5'($urandom_range(0, 31));
      if (code == 5'b00001 || code == 5'b00110) code = 5'b01000;
      scan_ir(code, cap);
      m_ir = code;
      checks++; if (cap !== 5'b00101) begin failures++; $display("FAIL ir_capture_rnd got=%b exp=00101", cap); end
      n = $urandom_range(2, 40);
      din = {$urandom, $urandom};
      e = exp_out(n, dr_len(m_ir), dr_cap(m_ir), din);
      scan_dr(n, din, dout);
      checks++;
      if ((dout & mask(n)) !== (e & mask(n))) begin
        failures++; $display("FAIL bypass_rnd ir=%b n=%0d got=%h exp=%h", code, n, dout & mask(n), e & mask(n));
      end
    end
  endtask

  task automatic test_confreg;
    logic [4:0] cap;
    logic [63:0] din, dout, e, r;
    logic b;
    int n;
    scan_ir(5'b00110, cap);
    m_ir = 5'b00110;
    scan_dr(9, 64'h002, dout);
    e = exp_out(9, 9, 64'(m_conf), 64'h002);
    m_conf = 9'h002; exp_upd++;
    checks++; if (dout[8:0] !== e[8:0]) begin failures++; $display("FAIL conf_first_out got=%h exp=%h", dout[8:0], e[8:0]); end
    checks++; if (conf !== 9'h002) begin failures++; $display("FAIL conf_write got=%h exp=002", conf); end
    checks++; if (upd_cnt !== exp_upd) begin failures++; $display("FAIL conf_upd_cnt got=%0d exp=%0d", upd_cnt, exp_upd); end
    din = {$urandom, $urandom};
    scan_dr(9, din, dout);
    checks++; if (dout[8:0] !== 9'h002) begin failures++; $display("FAIL conf_rescan got=%h exp=002", dout[8:0]); end
    m_conf = din[8:0]; exp_upd++;
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(3, 20);
      din = {$urandom, $urandom};
      e = exp_out(n, 9, 64'(m_conf), din);
      r = exp_reg(n, 9, 64'(m_conf), din);
      scan_dr(n, din, dout);
      m_conf = r[8:0]; exp_upd++;
      checks++;
      if ((dout & mask(n)) !== (e & mask(n))) begin
        failures++; $display("FAIL conf_rnd_out n=%0d got=%h exp=%h", n, dout & mask(n), e & mask(n));
      end
      checks++; if (conf !== m_conf) begin failures++; $display("FAIL conf_rnd_reg n=%0d got=%h exp=%h", n, conf, m_conf); end
    end
    // 9-bit scan split by a Pause-DR excursion
    din = {$urandom, $urandom};
    e = exp_out(9, 9, 64'(m_conf), din);
    dout = '0;
    tck_cycle(1, 0, b); tck_cycle(0, 0, b); tck_cycle(0, 0, b);
    for (int i = 0; i < 5; i++) begin tck_cycle(i == 4, din[i], b); dout[i] = b; end
    tck_cycle(0, 0, b); tck_cycle(0, 0, b); tck_cycle(1, 0, b); tck_cycle(0, 0, b);
    for (int i = 5; i < 9; i++) begin tck_cycle(i == 8, din[i], b); dout[i] = b; end
    tck_cycle(1, 0, b); tck_cycle(0, 0, b);
    m_conf = din[8:0]; exp_upd++;
    checks++; if (dout[8:0] !== e[8:0]) begin failures++; $display("FAIL conf_pause_out got=%h exp=%h", dout[8:0], e[8:0]); end
    checks++; if (conf !== m_conf) begin failures++; $display("FAIL conf_pause_reg got=%h exp=%h", conf, m_conf); end
    checks++; if (upd_cnt !== exp_upd) begin failures++; $display("FAIL conf_upd_total got=%0d exp=%0d", upd_cnt, exp_upd); end
  endtask

  task automatic test_trst;
    logic [4:0] cap;
    logic [63:0] dout, e;
    logic b;
    tck_cycle(1, 0, b); tck_cycle(0, 0, b); tck_cycle(0, 0, b);
    for (int i = 0; i < 4; i++) tck_cycle(0, $urandom_range(0, 1), b);
    trst_n = 1'b0;
    #50;
    trst_n = 1'b1;
    #50;
    m_ir = 5'b00001;
    checks++; if (tlr !== 1'b1) begin failures++; $display("FAIL trst_tlr got=%b exp=1", tlr); end
    checks++; if (conf !== m_conf) begin failures++; $display("FAIL trst_conf got=%h exp=%h", conf, m_conf); end
    checks++; if (upd_cnt !== exp_upd) begin failures++; $display("FAIL trst_upd got=%0d exp=%0d", upd_cnt, exp_upd); end
    tck_cycle(0, 0, b);
    e = exp_out(32, dr_len(m_ir), dr_cap(m_ir), 64'd0);
    scan_dr(32, 64'd0, dout);
    checks++; if (dout[31:0] !== e[31:0]) begin failures++; $display("FAIL trst_ir_idcode got=%h exp=%h", dout[31:0], e[31:0]); end
    scan_ir(5'b00110, cap);
    m_ir = 5'b00110;
    checks++; if (cap !== 5'b00101) begin failures++; $display("FAIL trst_ir_capture got=%b exp=00101", cap); end
  endtask

  task automatic test_rst_abort;
    logic [4:0] cap;
    logic [63:0] dout;
    logic b;
    scan_dr(9, 64'h155, dout);
    m_conf = 9'h155; exp_upd++;
    checks++; if (conf !== 9'h155) begin failures++; $display("FAIL abort_pre got=%h exp=155", conf); end
    tck_cycle(1, 0, b); tck_cycle(0, 0, b); tck_cycle(0, 0, b);
    for (int i = 0; i < 3; i++) tck_cycle(0, 1'b1, b);
    rst_n = 1'b0;
    #30;
    rst_n = 1'b1;
    #30;
    m_conf = 9'h000; m_ir = 5'b00001;
    checks++; if (conf !== 9'h000) begin failures++; $display("FAIL abort_conf got=%h exp=000", conf); end
    checks++; if (tlr !== 1'b1) begin failures++; $display("FAIL abort_tlr got=%b exp=1", tlr); end
    checks++; if (tdo !== 1'b0) begin failures++; $display("FAIL abort_tdo got=%b exp=0", tdo); end
    tck_cycle(0, 0, b);
    checks++; if (upd_cnt !== exp_upd) begin failures++; $display("FAIL abort_upd got=%0d exp=%0d", upd_cnt, exp_upd); end
    scan_ir(5'b00110, cap);
    m_ir = 5'b00110;
    scan_dr(9, 64'h0AA, dout);
    checks++; if (dout[8:0] !== 9'h000) begin failures++; $display("FAIL abort_recapture got=%h exp=000", dout[8:0]); end
  endtask

`ifdef JTAG_TAP_USERREG_EN
  task automatic test_userreg;
    logic [4:0] cap;
    logic [63:0] din, dout;
    int base;
    user_in = 32'hABBAABBA;
    scan_ir(5'b01000, cap);
    m_ir = 5'b01000;
    din = {32'd0, $urandom};
    base = user_upd_cnt;
    scan_dr(32, din, dout);
    checks++; if (dout[31:0] !== 32'hABBAABBA) begin failures++; $display("FAIL user_out got=%h exp=abbaabba", dout[31:0]); end
    checks++; if (user_out !== din[31:0]) begin failures++; $display("FAIL user_reg got=%h exp=%h", user_out, din[31:0]); end
    checks++; if (user_upd_cnt !== base + 1) begin failures++; $display("FAIL user_upd got=%0d exp=%0d", user_upd_cnt, base + 1); end
  endtask
`endif

  initial begin
    test_reset();
    test_idcode();
    test_bypass();
    test_confreg();
    test_trst();
    test_rst_abort();
`ifdef JTAG_TAP_USERREG_EN
    test_userreg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
